ctmm_save_burst: RTL and testbench
==================================

// Module: ctmm_save_burst
// PURPOSE
//  Parametrised multi-slot SAVE engine. Stores the Golden Tokens of COUNT consecutive source CRs
//  (CRs..CRs+COUNT-1) into consecutive C-List slots CRd[Index..Index+COUNT-1].
//  Performs the destination permission/bounds checks itself and adds a write-ack watchdog.
//  Sits beside the CHANGE/SAVE units in the Church-instruction execute stage and shares the CR read port and memory write port.
// PARAMETERS
//  NUM_CR       16   number of capability registers; CR index width = $clog2(NUM_CR)
//  MAX_CLIST_CR 6    highest CR allowed as destination C-List
//  IDX_W        8    C-List index width
//  MAX_BURST    8    maximum slots per instruction; count width CNT_W = $clog2(MAX_BURST+1)
//  ADDR_W       64   memory address width
//  GT_SHIFT     3    log2 bytes per GT slot (8-byte GT)
//  WR_TIMEOUT   255  cycles to wait for mem_wr_done before faulting; 0 disables the watchdog
// PORTS
//  clk          in   1         clock
//  rst          in   1         async active-high reset
//  save_start   in   1         start request; sampled only in IDLE
//  cr_src       in   CRW       first source CR
//  cr_dst       in   CRW       destination C-List CR
//  index        in   IDX_W     first C-List slot
//  count        in   CNT_W     slots to save, 0..MAX_BURST
//  save_busy    out  1         state != IDLE
//  save_complete out 1         1-cycle pulse on success
//  save_fault   out  1         1-cycle pulse on fault
//  fault_type   out  fault_type_t  cause; held until next accepted start
//  saved_count  out  CNT_W     slots actually written; held until next accepted start
//  cr_rd_addr   out  CRW       CR read address; data valid the following cycle
//  cr_rd_data   in   capability_reg_t  CR read data
//  mem_wr_addr  out  ADDR_W    slot address
//  mem_wr_data  out  64        GT to write
//  mem_wr_en    out  1         level; held until mem_wr_done sampled high
//  mem_wr_done  in   1         write acknowledge
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; fault_type=FAULT_NONE. Reset mid-operation drops mem_wr_en asynchronously.
//  start accepted in IDLE only; inputs latched at acceptance; save_start while busy is ignored.
//  States: IDLE -> RD_DST -> LAT_DST -> CHECK -> RD_SRC -> LAT_SRC -> WRITE -> (next slot RD_SRC | DONE); any check -> FAULT; DONE/FAULT -> IDLE.
//  count==0: IDLE -> DONE; save_complete asserts the cycle after start; no reads, no writes.
//  CHECK faults (FAULT_PERM): cr_dst>MAX_CLIST_CR; dst lacks S perm; dst has M or B set; cr_src+count-1>=NUM_CR (CRW+1-bit sum, no wrap).
//  Per-slot bounds check: slot = index+k in IDX_W+1 bits. Fault FAULT_BOUNDS if slot >= dst limit, before that slot's write.
//  Address: mem_wr_addr = dst base + (slot << GT_SHIFT), truncated modulo 2^ADDR_W; mem_wr_data = src word0_gt.
//  WRITE holds mem_wr_en/addr/data stable. mem_wr_done sampled high: saved_count++, k++; k==count -> DONE.
//  Watchdog: counter cleared on WRITE entry; reaching WR_TIMEOUT without done -> FAULT_TIMEOUT; mem_wr_en drops the same cycle.
//  mem_wr_done outside WRITE is ignored.
//  Partial writes on fault remain in memory; saved_count reports them.
//  Latency (count=N, ack 1 cycle after en): 3 + 3N cycles from start to complete pulse.
// CONFIGURATION
//  CTMM_SAVE_ATOMIC_EN defined: CHECK also verifies index+count-1 < limit. Any bounds fault is raised before any write,
//    so saved_count is 0 on every bounds fault. A timeout can still leave a partial burst.
//  Not defined: bounds checked per slot as above; earlier slots stay written.
// STRUCTURE
//  ctmm_pkg: add FAULT_BOUNDS and FAULT_TIMEOUT to fault_type_t if absent, and the save_burst_state_t enum.
//  Sub-module ctmm_save_slot_check: combinational dst-cap permission + slot bounds/address generator; shared with CHANGE.
// TESTING
//  1: dst CR2 (S set, base 0x1000, limit 16), src CR8, index 4, count 3, ack 1 cycle -> writes 0x1020/0x1028/0x1030,
//     GTs of CR8..CR10, complete at cycle 12, saved_count 3.
//  2: cr_dst=7 -> fault FAULT_PERM, no mem_wr_en, saved_count 0.
//  3: index 14, count 4, limit 16 -> macro off: 2 writes then FAULT_BOUNDS, saved_count 2;
//     macro on: FAULT_BOUNDS with 0 writes.
//  4: mem_wr_done held low, WR_TIMEOUT=4 -> FAULT_TIMEOUT 4 cycles after WRITE entry; en low the same cycle.
//  5: rst pulsed during WRITE -> mem_wr_en low immediately; busy 0; new start after reset completes normally.
//  6: count 0 -> complete next cycle, no traffic; save_start during busy -> ignored, busy pattern unchanged.

Source files
------------

// File: rtl/ctmm_pkg.sv
// ============================================================================
// Module      : ctmm_pkg
// Description : Shared types for the CTMM execute-stage units: capability
//               register layout, fault causes and the SAVE-burst state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctmm_pkg;

    localparam int CAP_ADDR_W  = 64;
    localparam int CAP_LIMIT_W = 32;
    localparam int GT_W        = 64;

    typedef struct packed {
        logic [GT_W-1:0]        word0_gt;
        logic [CAP_ADDR_W-1:0]  base;
        logic [CAP_LIMIT_W-1:0] limit;
        logic                   perm_s;
        logic                   perm_m;
        logic                   perm_b;
    } capability_reg_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_PERM    = 2'd1,
        FAULT_BOUNDS  = 2'd2,
        FAULT_TIMEOUT = 2'd3
    } fault_type_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_DST  = 4'd1,
        ST_LAT_DST = 4'd2,
        ST_CHECK   = 4'd3,
        ST_RD_SRC  = 4'd4,
        ST_LAT_SRC = 4'd5,
        ST_WRITE   = 4'd6,
        ST_DONE    = 4'd7,
        ST_FAULT   = 4'd8
    } save_burst_state_t;

endpackage

`default_nettype wire

// File: rtl/ctmm_save_burst_if.sv
// ============================================================================
// Module      : ctmm_save_burst_if
// Description : Request, CR read-port and memory write-port bundle of the SAVE
//               burst engine. master = engine side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctmm_save_burst_if #(
    parameter int CRW    = 4,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 4,
    parameter int ADDR_W = 64
);
    import ctmm_pkg::*;

    logic                  save_start;
    logic [CRW-1:0]        cr_src;
    logic [CRW-1:0]        cr_dst;
    logic [IDX_W-1:0]      index;
    logic [CNT_W-1:0]      count;
    logic                  save_busy;
    logic                  save_complete;
    logic                  save_fault;
    fault_type_t           fault_type;
    logic [CNT_W-1:0]      saved_count;
    logic [CRW-1:0]        cr_rd_addr;
    capability_reg_t       cr_rd_data;
    logic [ADDR_W-1:0]     mem_wr_addr;
    logic [GT_W-1:0]       mem_wr_data;
    logic                  mem_wr_en;
    logic                  mem_wr_done;

    modport master (
        input  save_start, cr_src, cr_dst, index, count, cr_rd_data, mem_wr_done,
        output save_busy, save_complete, save_fault, fault_type, saved_count,
               cr_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
    );

    modport slave (
        output save_start, cr_src, cr_dst, index, count, cr_rd_data, mem_wr_done,
        input  save_busy, save_complete, save_fault, fault_type, saved_count,
               cr_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
    );

endinterface

`default_nettype wire

// File: rtl/ctmm_save_slot_check.sv
// ============================================================================
// Module      : ctmm_save_slot_check
// Description : Combinational destination C-List permission check, slot bounds
//               check and slot address generation. Burst-end check present
//               when CTMM_SAVE_ATOMIC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctmm_save_slot_check
    import ctmm_pkg::*;
#(
    parameter int CRW          = 4,
    parameter int MAX_CLIST_CR = 6,
    parameter int IDX_W        = 8,
    parameter int CNT_W        = 4,
    parameter int ADDR_W       = 64,
    parameter int GT_SHIFT     = 3
) (
    input  logic [CRW-1:0]         cr_dst,
    input  logic                   perm_s,
    input  logic                   perm_m,
    input  logic                   perm_b,
    input  logic [CAP_ADDR_W-1:0]  dst_base,
    input  logic [CAP_LIMIT_W-1:0] dst_limit,
    input  logic [IDX_W-1:0]       index,
    input  logic [CNT_W-1:0]       k,
`ifdef CTMM_SAVE_ATOMIC_EN
    input  logic [CNT_W-1:0]       count,
    output logic                   burst_ok,
`endif
    output logic                   perm_ok,
    output logic                   slot_ok,
    output logic [ADDR_W-1:0]      slot_addr
);

    // One extra bit so index+k never wraps back inside the limit
    logic [IDX_W:0] slot;

    assign slot      = {1'b0, index} + (IDX_W+1)'(k);
    assign perm_ok   = (32'(cr_dst) <= 32'(MAX_CLIST_CR)) && perm_s && !perm_m && !perm_b;
    assign slot_ok   = CAP_LIMIT_W'(slot) < dst_limit;
    assign slot_addr = ADDR_W'(dst_base) + (ADDR_W'(slot) << GT_SHIFT);

`ifdef CTMM_SAVE_ATOMIC_EN
    logic [IDX_W:0] last_slot;

    assign last_slot = {1'b0, index} + (IDX_W+1)'(count) - (IDX_W+1)'(1);
    assign burst_ok  = CAP_LIMIT_W'(last_slot) < dst_limit;
`endif

endmodule

`default_nettype wire

// File: rtl/ctmm_save_burst.sv
// ============================================================================
// Module      : ctmm_save_burst
// Description : Multi-slot SAVE engine: writes the GTs of COUNT consecutive
//               source CRs into consecutive destination C-List slots, with
//               permission/bounds checks and a write-ack watchdog.
//               Define CTMM_SAVE_ATOMIC_EN to bounds-check the whole burst
//               before the first write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctmm_save_burst
    import ctmm_pkg::*;
#(
    parameter int NUM_CR       = 16,
    parameter int MAX_CLIST_CR = 6,
    parameter int IDX_W        = 8,
    parameter int MAX_BURST    = 8,
    parameter int ADDR_W       = 64,
    parameter int GT_SHIFT     = 3,
    parameter int WR_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    ctmm_save_burst_if.master bus
);

    localparam int CRW   = $clog2(NUM_CR);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int WD_W  = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WR_TIMEOUT - 1);

    save_burst_state_t      state_q, state_d;
    logic [CRW-1:0]         cr_src_q, cr_src_d;
    logic [CRW-1:0]         cr_dst_q, cr_dst_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       saved_q, saved_d;
    fault_type_t            fault_q, fault_d;
    logic [CAP_ADDR_W-1:0]  dst_base_q, dst_base_d;
    logic [CAP_LIMIT_W-1:0] dst_limit_q, dst_limit_d;
    logic                   dst_s_q, dst_s_d;
    logic                   dst_m_q, dst_m_d;
    logic                   dst_b_q, dst_b_d;
    logic [GT_W-1:0]        gt_q, gt_d;
    logic [WD_W-1:0]        wd_q, wd_d;

    logic                   perm_ok;
    logic                   slot_ok;
    logic [ADDR_W-1:0]      slot_addr;
    logic                   src_overrun;
    logic                   wd_expired;
`ifdef CTMM_SAVE_ATOMIC_EN
    logic                   burst_ok;
`endif

    ctmm_save_slot_check #(
        .CRW          (CRW),
        .MAX_CLIST_CR (MAX_CLIST_CR),
        .IDX_W        (IDX_W),
        .CNT_W        (CNT_W),
        .ADDR_W       (ADDR_W),
        .GT_SHIFT     (GT_SHIFT)
    ) u_slot_check (
        .cr_dst    (cr_dst_q),
        .perm_s    (dst_s_q),
        .perm_m    (dst_m_q),
        .perm_b    (dst_b_q),
        .dst_base  (dst_base_q),
        .dst_limit (dst_limit_q),
        .index     (index_q),
        .k         (k_q),
`ifdef CTMM_SAVE_ATOMIC_EN
        .count     (count_q),
        .burst_ok  (burst_ok),
`endif
        .perm_ok   (perm_ok),
        .slot_ok   (slot_ok),
        .slot_addr (slot_addr)
    );

    // Last source CR index computed one bit wider so it cannot wrap below NUM_CR
    assign src_overrun = ({1'b0, cr_src_q} + (CRW+1)'(count_q) - (CRW+1)'(1))
                         >= (CRW+1)'(NUM_CR);
    assign wd_expired  = (WR_TIMEOUT != 0) && (wd_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        cr_src_d    = cr_src_q;
        cr_dst_d    = cr_dst_q;
        index_d     = index_q;
        count_d     = count_q;
        k_d         = k_q;
        saved_d     = saved_q;
        fault_d     = fault_q;
        dst_base_d  = dst_base_q;
        dst_limit_d = dst_limit_q;
        dst_s_d     = dst_s_q;
        dst_m_d     = dst_m_q;
        dst_b_d     = dst_b_q;
        gt_d        = gt_q;
        wd_d        = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.save_start) begin
                    cr_src_d = bus.cr_src;
                    cr_dst_d = bus.cr_dst;
                    index_d  = bus.index;
                    count_d  = bus.count;
                    k_d      = '0;
                    saved_d  = '0;
                    fault_d  = FAULT_NONE;
                    state_d  = (bus.count == '0) ? ST_DONE : ST_RD_DST;
                end
            end
            ST_RD_DST:  state_d = ST_LAT_DST;
            ST_LAT_DST: begin
                dst_base_d  = bus.cr_rd_data.base;
                dst_limit_d = bus.cr_rd_data.limit;
                dst_s_d     = bus.cr_rd_data.perm_s;
                dst_m_d     = bus.cr_rd_data.perm_m;
                dst_b_d     = bus.cr_rd_data.perm_b;
                state_d     = ST_CHECK;
            end
            ST_CHECK: begin
                if (!perm_ok || src_overrun) begin
                    fault_d = FAULT_PERM;
                    state_d = ST_FAULT;
`ifdef CTMM_SAVE_ATOMIC_EN
                end else if (!burst_ok) begin
                    fault_d = FAULT_BOUNDS;
                    state_d = ST_FAULT;
`endif
                end else begin
                    state_d = ST_RD_SRC;
                end
            end
            ST_RD_SRC:  state_d = ST_LAT_SRC;
            ST_LAT_SRC: begin
                gt_d = bus.cr_rd_data.word0_gt;
                if (!slot_ok) begin
                    fault_d = FAULT_BOUNDS;
                    state_d = ST_FAULT;
                end else begin
                    wd_d    = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // An ack on the expiry edge still counts as a completed write
                if (bus.mem_wr_done) begin
                    saved_d = saved_q + CNT_W'(1);
                    k_d     = k_q + CNT_W'(1);
                    state_d = (k_d == count_q) ? ST_DONE : ST_RD_SRC;
                end else if (wd_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_FAULT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cr_src_q    <= '0;
            cr_dst_q    <= '0;
            index_q     <= '0;
            count_q     <= '0;
            k_q         <= '0;
            saved_q     <= '0;
            fault_q     <= FAULT_NONE;
            dst_base_q  <= '0;
            dst_limit_q <= '0;
            dst_s_q     <= 1'b0;
            dst_m_q     <= 1'b0;
            dst_b_q     <= 1'b0;
            gt_q        <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cr_src_q    <= cr_src_d;
            cr_dst_q    <= cr_dst_d;
            index_q     <= index_d;
            count_q     <= count_d;
            k_q         <= k_d;
            saved_q     <= saved_d;
            fault_q     <= fault_d;
            dst_base_q  <= dst_base_d;
            dst_limit_q <= dst_limit_d;
            dst_s_q     <= dst_s_d;
            dst_m_q     <= dst_m_d;
            dst_b_q     <= dst_b_d;
            gt_q        <= gt_d;
            wd_q        <= wd_d;
        end
    end

    always_comb begin
        bus.cr_rd_addr = '0;
        if (state_q == ST_RD_DST) begin
            bus.cr_rd_addr = cr_dst_q;
        end else if (state_q == ST_RD_SRC) begin
            bus.cr_rd_addr = cr_src_q + CRW'(k_q);
        end
    end

    // Write strobe decodes straight from the state flop so reset removes it at once
    assign bus.mem_wr_en     = (state_q == ST_WRITE);
    assign bus.mem_wr_addr   = bus.mem_wr_en ? slot_addr : '0;
    assign bus.mem_wr_data   = bus.mem_wr_en ? gt_q : '0;
    assign bus.save_busy     = (state_q != ST_IDLE);
    assign bus.save_complete = (state_q == ST_DONE);
    assign bus.save_fault    = (state_q == ST_FAULT);
    assign bus.fault_type    = fault_q;
    assign bus.saved_count   = saved_q;

endmodule

`default_nettype wire

// File: tb/tb_ctmm_save_burst.sv
// ============================================================================
// Module      : tb_ctmm_save_burst
// Description : Directed self-checking bench for ctmm_save_burst (watchdog set
//               to 4 cycles). Expectations follow CTMM_SAVE_ATOMIC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctmm_save_burst;
    import ctmm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack_en = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t0 = 0;
    int   wr_n = 0;
    int   en_total = 0;
    int   busy_total = 0;
    int   wr_base, en_base, busy_base, lat;
    logic end_cmp, end_flt, end_en;
    logic [63:0] wr_addr_log [64];
    logic [63:0] wr_data_log [64];
    capability_reg_t cr_mem [16];

    always #5 clk = ~clk;

    ctmm_save_burst_if #(.CRW(4), .IDX_W(8), .CNT_W(4), .ADDR_W(64)) bus ();

    ctmm_save_burst #(
        .NUM_CR(16), .MAX_CLIST_CR(6), .IDX_W(8), .MAX_BURST(8),
        .ADDR_W(64), .GT_SHIFT(3), .WR_TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CR file with one-cycle read latency
    always @(posedge clk) bus.cr_rd_data <= cr_mem[bus.cr_rd_addr];

    // Ack raised mid-cycle after the strobe so it is sampled at the next edge
    always @(negedge clk) bus.mem_wr_done = ack_en & bus.mem_wr_en;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_wr_en && bus.mem_wr_done) begin
            wr_addr_log[wr_n % 64] <= bus.mem_wr_addr;
            wr_data_log[wr_n % 64] <= bus.mem_wr_data;
            wr_n <= wr_n + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.mem_wr_en) en_total <= en_total + 1;
        if (bus.save_busy) busy_total <= busy_total + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] src, input logic [3:0] dst,
                         input logic [7:0] idx, input logic [3:0] cnt);
        @(negedge clk);
        bus.cr_src     = src;
        bus.cr_dst     = dst;
        bus.index      = idx;
        bus.count      = cnt;
        bus.save_start = 1'b1;
        @(posedge clk);
        #1;
        t0             = cyc;
        bus.save_start = 1'b0;
        wr_base        = wr_n;
        en_base        = en_total;
        busy_base      = busy_total;
    endtask

    task automatic wait_end(input string tag);
        lat     = -1;
        end_cmp = 1'b0;
        end_flt = 1'b0;
        end_en  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.save_complete || bus.save_fault) begin
                lat     = cyc - t0;
                end_cmp = bus.save_complete;
                end_flt = bus.save_fault;
                end_en  = bus.mem_wr_en;
                break;
            end
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: no complete/fault within 100 cycles", tag);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            cr_mem[i]          = '0;
            cr_mem[i].word0_gt = 64'hA000_0000_0000_0000 | 64'(i);
        end
        cr_mem[2].base   = 64'h1000;
        cr_mem[2].limit  = 32'd16;
        cr_mem[2].perm_s = 1'b1;
        cr_mem[7].base   = 64'h2000;
        cr_mem[7].limit  = 32'd16;
        cr_mem[7].perm_s = 1'b1;
        cr_mem[3].base   = 64'h3000;
        cr_mem[3].limit  = 32'd16;
        cr_mem[3].perm_s = 1'b1;
        cr_mem[3].perm_m = 1'b1;

        bus.save_start = 1'b0;
        bus.cr_src     = '0;
        bus.cr_dst     = '0;
        bus.index      = '0;
        bus.count      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",     64'(bus.save_busy), 64'd0);
        chk("rst_complete", 64'(bus.save_complete), 64'd0);
        chk("rst_fault",    64'(bus.save_fault), 64'd0);
        chk("rst_ftype",    64'(bus.fault_type), 64'(FAULT_NONE));
        chk("rst_saved",    64'(bus.saved_count), 64'd0);
        chk("rst_wr_en",    64'(bus.mem_wr_en), 64'd0);
        chk("rst_rd_addr",  64'(bus.cr_rd_addr), 64'd0);

        // Three-slot burst into CR2 slots 4..6
        ack_en = 1'b1;
        start(4'd8, 4'd2, 8'd4, 4'd3);
        wait_end("t1");
        chk("t1_latency",  64'(lat), 64'd12);
        chk("t1_complete", 64'(end_cmp), 64'd1);
        chk("t1_fault",    64'(end_flt), 64'd0);
        chk("t1_ftype",    64'(bus.fault_type), 64'(FAULT_NONE));
        chk("t1_saved",    64'(bus.saved_count), 64'd3);
        settle();
        chk("t1_writes",   64'(wr_n - wr_base), 64'd3);
        chk("t1_addr0",    wr_addr_log[(wr_base + 0) % 64], 64'h1020);
        chk("t1_addr1",    wr_addr_log[(wr_base + 1) % 64], 64'h1028);
        chk("t1_addr2",    wr_addr_log[(wr_base + 2) % 64], 64'h1030);
        chk("t1_data0",    wr_data_log[(wr_base + 0) % 64], 64'hA000_0000_0000_0008);
        chk("t1_data1",    wr_data_log[(wr_base + 1) % 64], 64'hA000_0000_0000_0009);
        chk("t1_data2",    wr_data_log[(wr_base + 2) % 64], 64'hA000_0000_0000_000A);
        chk("t1_idle",     64'(bus.save_busy), 64'd0);

        // Destination above the C-List range
        start(4'd8, 4'd7, 8'd0, 4'd1);
        wait_end("t2");
        chk("t2_latency", 64'(lat), 64'd3);
        chk("t2_fault",   64'(end_flt), 64'd1);
        chk("t2_ftype",   64'(bus.fault_type), 64'(FAULT_PERM));
        chk("t2_saved",   64'(bus.saved_count), 64'd0);
        settle();
        chk("t2_no_en",   64'(en_total - en_base), 64'd0);

        // Destination with M set
        start(4'd8, 4'd3, 8'd0, 4'd1);
        wait_end("t2b");
        chk("t2b_fault",  64'(end_flt), 64'd1);
        chk("t2b_ftype",  64'(bus.fault_type), 64'(FAULT_PERM));
        settle();

        // Source range 14..16 runs past the CR file
        start(4'd14, 4'd2, 8'd0, 4'd3);
        wait_end("t2c");
        chk("t2c_fault",  64'(end_flt), 64'd1);
        chk("t2c_ftype",  64'(bus.fault_type), 64'(FAULT_PERM));
        settle();
        chk("t2c_no_en",  64'(en_total - en_base), 64'd0);

        // Burst ending exactly on the last legal slot 15
        start(4'd8, 4'd2, 8'd13, 4'd3);
        wait_end("t3a");
        chk("t3a_complete", 64'(end_cmp), 64'd1);
        chk("t3a_saved",    64'(bus.saved_count), 64'd3);
        settle();
        chk("t3a_addr2",    wr_addr_log[(wr_base + 2) % 64], 64'h1078);

        // Burst crossing the limit: slots 14,15 legal, 16 not
        start(4'd8, 4'd2, 8'd14, 4'd4);
        wait_end("t3");
        chk("t3_fault",  64'(end_flt), 64'd1);
        chk("t3_ftype",  64'(bus.fault_type), 64'(FAULT_BOUNDS));
`ifdef CTMM_SAVE_ATOMIC_EN
        chk("t3_latency", 64'(lat), 64'd3);
        chk("t3_saved",   64'(bus.saved_count), 64'd0);
        settle();
        chk("t3_writes",  64'(wr_n - wr_base), 64'd0);
`else
        chk("t3_latency", 64'(lat), 64'd11);
        chk("t3_saved",   64'(bus.saved_count), 64'd2);
        settle();
        chk("t3_writes",  64'(wr_n - wr_base), 64'd2);
        chk("t3_addr0",   wr_addr_log[(wr_base + 0) % 64], 64'h1070);
        chk("t3_addr1",   wr_addr_log[(wr_base + 1) % 64], 64'h1078);
`endif

        // No ack: watchdog fires 4 cycles after WRITE entry
        ack_en = 1'b0;
        start(4'd8, 4'd2, 8'd0, 4'd2);
        wait_end("t4");
        chk("t4_latency", 64'(lat), 64'd9);
        chk("t4_fault",   64'(end_flt), 64'd1);
        chk("t4_ftype",   64'(bus.fault_type), 64'(FAULT_TIMEOUT));
        chk("t4_saved",   64'(bus.saved_count), 64'd0);
        chk("t4_en_drop", 64'(end_en), 64'd0);
        settle();
        chk("t4_en_cycles", 64'(en_total - en_base), 64'd4);

        // Reset while the write strobe is up
        start(4'd8, 4'd2, 8'd0, 4'd2);
        end_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en) begin
                end_en = 1'b1;
                break;
            end
        end
        chk("t5_en_seen", 64'(end_en), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_en_async", 64'(bus.mem_wr_en), 64'd0);
        chk("t5_busy",     64'(bus.save_busy), 64'd0);
        chk("t5_ftype",    64'(bus.fault_type), 64'(FAULT_NONE));
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        start(4'd8, 4'd2, 8'd4, 4'd3);
        wait_end("t5b");
        chk("t5b_latency",  64'(lat), 64'd12);
        chk("t5b_complete", 64'(end_cmp), 64'd1);
        chk("t5b_saved",    64'(bus.saved_count), 64'd3);
        settle();

        // Zero-length burst
        start(4'd8, 4'd2, 8'd0, 4'd0);
        wait_end("t6");
        chk("t6_latency",  64'(lat), 64'd0);
        chk("t6_complete", 64'(end_cmp), 64'd1);
        chk("t6_saved",    64'(bus.saved_count), 64'd0);
        settle();
        chk("t6_no_en",    64'(en_total - en_base), 64'd0);

        // Start re-asserted with a faulting destination while busy
        start(4'd8, 4'd2, 8'd5, 4'd1);
        bus.cr_dst     = 4'd7;
        bus.save_start = 1'b1;
        wait_end("t6b");
        bus.save_start = 1'b0;
        chk("t6b_latency",  64'(lat), 64'd6);
        chk("t6b_complete", 64'(end_cmp), 64'd1);
        chk("t6b_ftype",    64'(bus.fault_type), 64'(FAULT_NONE));
        settle();
        chk("t6b_busy_cyc", 64'(busy_total - busy_base), 64'd7);
        chk("t6b_writes",   64'(wr_n - wr_base), 64'd1);
        chk("t6b_addr",     wr_addr_log[wr_base % 64], 64'h1028);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
